// File: rtl/frame_readout_ctrl_pkg.sv
// Shared types and constants for the thermostat frame readout sequencer.
// Byte map of the decoded frame as presented by the frame multiplexer.
package frame_readout_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4,
        ST_DRAIN   = 3'd5
    } state_e;

    localparam int FRAME_BYTES_DEFAULT   = 12;
    localparam int SETTLE_CYCLES_DEFAULT = 1;

    localparam logic [3:0] ADDR_ID0   = 4'd0;
    localparam logic [3:0] ADDR_ID1   = 4'd1;
    localparam logic [3:0] ADDR_ID2   = 4'd2;
    localparam logic [3:0] ADDR_ID3   = 4'd3;
    localparam logic [3:0] ADDR_ROOM0 = 4'd4;
    localparam logic [3:0] ADDR_ROOM1 = 4'd5;
    localparam logic [3:0] ADDR_SET0  = 4'd6;
    localparam logic [3:0] ADDR_SET1  = 4'd7;
    localparam logic [3:0] ADDR_STATE = 4'd8;
    localparam logic [3:0] ADDR_TAIL1 = 4'd9;
    localparam logic [3:0] ADDR_TAIL2 = 4'd10;
    localparam logic [3:0] ADDR_TAIL3 = 4'd11;

    function automatic logic [3:0] last_index(input int frame_bytes);
        last_index = 4'(frame_bytes - 1);
    endfunction

    // States during which the decoder must be frozen.
    function automatic logic is_readout_state(input state_e s);
        is_readout_state = (s == ST_HOLD) || (s == ST_FETCH) || (s == ST_PRESENT);
    endfunction

endpackage

// File: rtl/frame_readout_ctrl_sat_counter8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module sat_counter8 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       inc,
    output logic [7:0] count
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/frame_readout_ctrl.sv
// Reads a completed frame out of the byte multiplexer as a valid/ready stream,
// freezing the decoder during readout and pulsing frame_clear when done.
module frame_readout_ctrl
    import frame_readout_ctrl_pkg::*;
#(
    parameter int FRAME_BYTES   = FRAME_BYTES_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       full,
    input  logic [7:0] mux_data,
    output logic [3:0] address,
    output logic       rx_enable,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_clear,
    output logic [7:0] dropped
);

    localparam logic [3:0] LAST_IDX    = last_index(FRAME_BYTES);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] index_q, index_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] address_q, address_d;
    logic       rx_enable_q, rx_enable_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       frame_clear_q, frame_clear_d;
    logic       full_q;
    logic       drop_inc_s;

    // Sequencer next-state, byte index and settle countdown.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        settle_d    = settle_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (full) begin
                    state_d  = ST_HOLD;
                    index_d  = 4'd0;
                    settle_d = SETTLE_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (settle_q <= 4'd1) begin
                    settle_d = 4'd0;
                    state_d  = ST_FETCH;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_FETCH: begin
                out_data_d  = mux_data;
                out_valid_d = 1'b1;
                state_d     = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (index_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_DONE: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Wait for the decoder to drop full so the same frame is not reread.
                if (!full) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        rx_enable_d   = !is_readout_state(state_d);
        frame_clear_d = (state_d == ST_DONE);
        if ((state_d == ST_FETCH) || (state_d == ST_PRESENT)) begin
            address_d = index_d;
        end else begin
            address_d = ADDR_ID0;
        end
    end

    assign drop_inc_s = full && !full_q && (state_q != ST_IDLE);

    // Sequencer and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            index_q       <= 4'd0;
            settle_q      <= 4'd0;
            address_q     <= 4'd0;
            rx_enable_q   <= 1'b1;
            out_data_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            frame_clear_q <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            settle_q      <= settle_d;
            address_q     <= address_d;
            rx_enable_q   <= rx_enable_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_clear_q <= frame_clear_d;
            full_q        <= full;
        end
    end

    sat_counter8 u_dropped (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (drop_inc_s),
        .count   (dropped)
    );

    assign address     = address_q;
    assign rx_enable   = rx_enable_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_clear = frame_clear_q;

endmodule

// File: doc/frame_readout_ctrl.md
# frame_readout_ctrl

Sequences readout of a decoded thermostat frame from the byte-addressed frame multiplexer (12 bytes, addresses 0–11) into a valid/ready byte stream for the host-side interface. It waits for the serial decoder's `full` flag, gates reception off while the frame is read, steps the multiplexer address, and presents each byte with a handshake. It then pulses `frame_clear` so the decoder can re-arm, and re-enables reception. It sits between the frame multiplexer and the output/host interface logic.

## Interface
- `FRAME_BYTES`, 12: number of bytes read per frame; addresses `0..FRAME_BYTES-1`; range 1–16.
- `SETTLE_CYCLES`, 1: hold cycles after gating RX before the first address fetch; range 1–15.

- `clock`  in  1  single system clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `full`  in  1  decoder frame-complete flag, level.
- `mux_data`  in  8  multiplexer byte for the current `address`; combinational, valid in the same cycle.
- `address`  out  4  multiplexer byte select.
- `rx_enable`  out  1  1 = decoder may receive; 0 = frame frozen for readout.
- `out_data`  out  8  registered byte to host.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  host accepts when `out_valid && out_ready`.
- `frame_clear`  out  1  one-cycle pulse: frame consumed, decoder may re-arm.
- `dropped`  out  8  saturating count of `full` rising edges seen outside IDLE.

## Operation
- **Reset values:** state IDLE, `address`=0, `rx_enable`=1, `out_data`=0, `out_valid`=0, `frame_clear`=0, `dropped`=0, byte index=0, settle counter=0.
- **States:**
  - IDLE: `rx_enable`=1. `full`=1 → HOLD, index=0, settle counter=`SETTLE_CYCLES`.
  - HOLD: `rx_enable`=0. Counter decrements each cycle; on reaching 0 (after `SETTLE_CYCLES` cycles in HOLD) → FETCH.
  - FETCH: `address`=index. Register `mux_data` into `out_data` and set `out_valid`=1 → PRESENT.
  - PRESENT: `address` and `out_data` held stable while `out_valid`=1. On handshake, `out_valid` drops next cycle. If index=`FRAME_BYTES`-1 → DONE, else index+1 → FETCH.
  - DONE: `frame_clear`=1 for exactly one cycle, `rx_enable`=1 → DRAIN.
  - DRAIN: wait for `full`=0, then → IDLE. This prevents rereading the same frame.
- **RX gating:** `rx_enable`=0 in HOLD, FETCH and PRESENT only.
- **Address:** `address`=0 in IDLE, DONE and DRAIN. Index width 4 bits, so no wrap for the legal `FRAME_BYTES` range.
- **Dropped counter:** `full` rising edge (registered previous value) in any state other than IDLE → `dropped`+1, saturating at 255. Not cleared except by reset.
- **Back-pressure:** `out_ready` low in PRESENT holds indefinitely, with no timeout. `out_ready` in other states is ignored.
- **Async reset mid-frame:** immediate return to reset values. Any partially sent frame is abandoned, with no `frame_clear`.

## Timing
- `full` sampled high at edge N: HOLD from N+1 (`rx_enable`=0 at N+1). FETCH at N+1+`SETTLE_CYCLES`. First `out_valid` at N+2+`SETTLE_CYCLES`.
- Throughput with `out_ready` held high: one byte per 2 cycles.
- Full frame with `SETTLE_CYCLES`=1 and no stalls: `out_valid` first at N+3. Last handshake at N+3+2·(`FRAME_BYTES`-1). `frame_clear` on the following cycle.
- `full` falling during HOLD, FETCH or PRESENT is ignored; the readout completes.
- `full` low when DONE is entered: DRAIN exits to IDLE after one cycle.

## Structure
- Shared package:
  - state enum (IDLE, HOLD, FETCH, PRESENT, DONE, DRAIN)
  - frame byte-address constants 0–11 (ID0–3, ROOM0–1, SET0–1, STATE, TAIL1–3)
  - default `FRAME_BYTES`=12
- One sub-module: `sat_counter8` (increment enable, saturate at 255, async active-low reset) for `dropped`.
- The FSM, index and settle counter live in the top-level module.

## Test plan
- **Reset check:** assert `reset_n`=0 → all outputs at reset values; `rx_enable`=1, `dropped`=0.
- **Full frame, no stalls:** bytes 0x10..0x1B at addresses 0–11, `full` pulse at N, `out_ready`=1 → 12 bytes 0x10..0x1B in order, first at N+3. `frame_clear` single pulse after the 12th byte. `rx_enable` low throughout readout.
- **Back-pressure:** `out_ready` held 0 for 5 cycles on byte 4 → `out_data`=0x14 and `address`=4 stable all 5 cycles, with no duplicated or skipped byte.
- **Dropped frames:** `full` toggled 0→1 three times during readout → `dropped`=3. Also run 300 such edges → `dropped`=255.
- **DRAIN:** `full` held 1 after DONE → state stays DRAIN and no second readout. Drop `full` → IDLE one cycle later.
- **Reset mid-frame:** `reset_n` low during byte 6 → immediate reset values and no `frame_clear`. The next `full` starts a fresh readout at address 0.
